// File: rtl/mux3_rr_arbiter.sv
// rtl/mux3_rr_arbiter.sv - round-robin 3:1 select arbiter with registered valid/ready output (optional stats: MUX3_ARB_STATS_EN)
module mux3_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [2:0]       Req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [2:0]       Ack,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
`ifdef MUX3_ARB_STATS_EN
    input  logic             Cnt_clr,
    output logic [CNT_W-1:0] Cnt0,
    output logic [CNT_W-1:0] Cnt1,
    output logic [CNT_W-1:0] Cnt2,
`endif
    input  logic             Y_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Counter width must be usable even though counters only exist in the stats build.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [0:0]       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       ack_q, ack_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic [2:0]       elig;
    logic [1:0]       cand0, cand1, cand2;
    logic [1:0]       win;
    logic [WIDTH-1:0] win_data;
    logic             capture;

    // Pick the first eligible source after the last grant; a source acked this cycle is masked.
    always_comb begin
        elig = Req & ~ack_q;
        case (last_q)
            2'd0:    begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
            2'd1:    begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
            default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
        endcase
        if (elig[cand0]) begin
            win = cand0;
        end else if (elig[cand1]) begin
            win = cand1;
        end else begin
            win = cand2;
        end
        case (win)
            2'd0:    win_data = D0;
            2'd1:    win_data = D1;
            default: win_data = D2;
        endcase
        capture = (elig != 3'b000) && ((state_q == ST_IDLE) || Y_ready);
    end

    // Next-state: capture a new word, drain a consumed word, or hold under backpressure.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        s_d     = s_q;
        y_d     = y_q;
        ack_d   = 3'b000;
        if (capture) begin
            state_d = ST_FULL;
            last_d  = win;
            s_d     = win;
            y_d     = win_data;
            ack_d   = 3'b001 << win;
        end else if ((state_q == ST_FULL) && Y_ready) begin
            state_d = ST_IDLE;
        end
    end

    // Arbiter and output registers; last grant resets to source 2 so source 0 goes first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd2;
            ack_q   <= 3'b000;
            s_q     <= 2'd0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    assign Ack     = ack_q;
    assign S       = s_q;
    assign Y       = y_q;
    assign Y_valid = (state_q == ST_FULL);

`ifdef MUX3_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Saturating per-source grant counters; clear takes priority over a same-cycle grant.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (Cnt_clr) begin
                cnt_d[k] = '0;
            end else if (capture && (win == 2'(k)) && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign Cnt0 = cnt_q[0];
    assign Cnt1 = cnt_q[1];
    assign Cnt2 = cnt_q[2];
`endif

endmodule
